// File: rtl/rv32_regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Forwarding build option: RV32_REGFILE_BYPASS_EN.
package rv32_regfile_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;
  localparam int MAX_WRITE     = 3;
  localparam int MAX_IDX_W     = 6;

  // Highest enabled port hitting idx wins; -1 when none or idx is zero.
  function automatic int win_port(
    input logic [MAX_WRITE-1:0]           we,
    input logic [MAX_WRITE*MAX_IDX_W-1:0] widx,
    input logic [MAX_IDX_W-1:0]           idx
  );
    int sel;
    sel = -1;
    for (int p = 0; p < MAX_WRITE; p++) begin
      if (we[p] && idx != '0 &&
          widx[p*MAX_IDX_W +: MAX_IDX_W] == idx)
        sel = p;
    end
    return sel;
  endfunction

endpackage

// File: rtl/rv32_mod_regfile_wrsel.sv
// Write-port selector: hit and data of the winning port for one index.
// Used for storage update and for read forwarding.
module rv32_mod_regfile_wrsel
  import rv32_regfile_pkg::*;
#(
  parameter int XLEN      = XLEN_DEFAULT,
  parameter int NUM_WRITE = 1,
  parameter int IDX_W     = 5
) (
  input  logic [NUM_WRITE-1:0]       write_enable,
  input  logic [NUM_WRITE*IDX_W-1:0] write_index,
  input  logic [NUM_WRITE*XLEN-1:0]  write_data,
  input  logic [IDX_W-1:0]           index,
  output logic                       hit,
  output logic [XLEN-1:0]            data
);

  logic [MAX_WRITE-1:0]           we_pad;
  logic [MAX_WRITE*MAX_IDX_W-1:0] wi_pad;
  logic [MAX_IDX_W-1:0]           idx_pad;
  int                             sel;

  always_comb begin
    we_pad  = '0;
    wi_pad  = '0;
    idx_pad = MAX_IDX_W'(index);
    for (int p = 0; p < NUM_WRITE; p++) begin
      we_pad[p] = write_enable[p];
      wi_pad[p*MAX_IDX_W +: MAX_IDX_W] =
        MAX_IDX_W'(write_index[p*IDX_W +: IDX_W]);
    end
    sel  = win_port(we_pad, wi_pad, idx_pad);
    hit  = (sel >= 0);
    data = '0;
    for (int p = 0; p < NUM_WRITE; p++) begin
      if (sel == p)
        data = write_data[p*XLEN +: XLEN];
    end
  end

endmodule

// File: rtl/rv32_mod_regfile_mp.sv
// Parametrised multi-port integer register file with clear engine.
// Optional write-to-read forwarding: define RV32_REGFILE_BYPASS_EN.
module rv32_mod_regfile_mp
  import rv32_regfile_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int NREGS      = NREGS_DEFAULT,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 1,
  parameter int ASYNC_READ = 1,
  parameter int IDX_W      = $clog2(NREGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       init_busy,
  input  logic [NUM_READ*IDX_W-1:0]  read_index,
  output logic [NUM_READ*XLEN-1:0]   read_data,
  input  logic [NUM_WRITE*IDX_W-1:0] write_index,
  input  logic [NUM_WRITE*XLEN-1:0]  write_data,
  input  logic [NUM_WRITE-1:0]       write_enable
);

  localparam logic [0:0] S_CLEAR = CLEAR;
  localparam logic [0:0] S_RUN   = RUN;

  logic [0:0]       state;
  logic [IDX_W-1:0] clr_cnt;
  logic [XLEN-1:0]  regs [NREGS];
  logic             reg_hit [NREGS];
  logic [XLEN-1:0]  reg_wdata [NREGS];

  assign init_busy = (state == S_CLEAR);

  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    rv32_mod_regfile_wrsel #(
      .XLEN      (XLEN),
      .NUM_WRITE (NUM_WRITE),
      .IDX_W     (IDX_W)
    ) u_wrsel (
      .write_enable (write_enable),
      .write_index  (write_index),
      .write_data   (write_data),
      .index        (IDX_W'(r)),
      .hit          (reg_hit[r]),
      .data         (reg_wdata[r])
    );
  end

  // Register 0 is never written; reads of it are forced to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_CLEAR;
      clr_cnt <= IDX_W'(1);
    end else if (state == S_CLEAR) begin
      regs[clr_cnt] <= '0;
      clr_cnt       <= clr_cnt + 1'b1;
      if (clr_cnt == IDX_W'(NREGS-1))
        state <= S_RUN;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (reg_hit[r])
          regs[r] <= reg_wdata[r];
      end
    end
  end

  for (genvar q = 0; q < NUM_READ; q++) begin : g_rd
    logic [IDX_W-1:0] ridx;
    logic [XLEN-1:0]  rval;

    assign ridx = read_index[q*IDX_W +: IDX_W];

`ifdef RV32_REGFILE_BYPASS_EN
    logic            fwd_hit;
    logic [XLEN-1:0] fwd_data;

    rv32_mod_regfile_wrsel #(
      .XLEN      (XLEN),
      .NUM_WRITE (NUM_WRITE),
      .IDX_W     (IDX_W)
    ) u_fwd (
      .write_enable (write_enable),
      .write_index  (write_index),
      .write_data   (write_data),
      .index        (ridx),
      .hit          (fwd_hit),
      .data         (fwd_data)
    );

    always_comb begin
      rval = regs[ridx];
      if (fwd_hit && state == S_RUN)
        rval = fwd_data;
      if (ridx == '0 || state == S_CLEAR)
        rval = '0;
    end
`else
    always_comb begin
      rval = regs[ridx];
      if (ridx == '0 || state == S_CLEAR)
        rval = '0;
    end
`endif

    if (ASYNC_READ != 0) begin : g_async
      assign read_data[q*XLEN +: XLEN] = rval;
    end else begin : g_sync
      logic [XLEN-1:0] rdata_q;

      always_ff @(posedge clk) begin
        if (rst)
          rdata_q <= '0;
        else
          rdata_q <= rval;
      end

      assign read_data[q*XLEN +: XLEN] = rdata_q;
    end
  end

endmodule

// File: tb/tb_rv32_mod_regfile_mp.sv
// Directed bench for rv32_mod_regfile_mp: async and sync instances.
// Expected forwarding values follow RV32_REGFILE_BYPASS_EN.
module tb_rv32_mod_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy_a, busy_s;
  logic [9:0]  ridx;
  logic [63:0] rdata_a, rdata_s;
  logic [9:0]  widx;
  logic [63:0] wdat;
  logic [1:0]  we;

  int total = 0;
  int fails = 0;
  int n;

  always #5 clk = ~clk;

  rv32_mod_regfile_mp #(
    .NUM_READ (2), .NUM_WRITE (2), .ASYNC_READ (1)
  ) u_dut (
    .clk (clk), .rst (rst), .init_busy (busy_a),
    .read_index (ridx), .read_data (rdata_a),
    .write_index (widx), .write_data (wdat),
    .write_enable (we)
  );

  rv32_mod_regfile_mp #(
    .NUM_READ (2), .NUM_WRITE (2), .ASYNC_READ (0)
  ) u_dut_s (
    .clk (clk), .rst (rst), .init_busy (busy_s),
    .read_index (ridx), .read_data (rdata_s),
    .write_index (widx), .write_data (wdat),
    .write_enable (we)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ra(input int p);
    return rdata_a[p*32 +: 32];
  endfunction

  function automatic logic [31:0] rs(input int p);
    return rdata_s[p*32 +: 32];
  endfunction

  task automatic wr(input int p, input logic [4:0] i,
                    input logic [31:0] d);
    @(negedge clk);
    we = '0;
    we[p] = 1'b1;
    widx[p*5 +: 5] = i;
    wdat[p*32 +: 32] = d;
    @(negedge clk);
    we = '0;
  endtask

  task automatic wait_clear(output int cnt);
    cnt = 0;
    while (busy_a && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic rd2(input logic [4:0] i0,
                     input logic [4:0] i1);
    ridx = {i1, i0};
    #1;
  endtask

  initial begin
    logic [31:0] exp_fwd;
    rst = 1'b1; ridx = '0; widx = '0;
    wdat = '0; we = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy_a", 32'(busy_a), 32'd1);
    chk("rst_busy_s", 32'(busy_s), 32'd1);
    chk("rst_rd_a", ra(0), 32'h0);
    chk("rst_rd_s", rs(1), 32'h0);

    // Release reset while port0 tries to write reg3.
    rst = 1'b0;
    we = 2'b01; widx = 10'd3;
    wdat = 64'h1234;
    ridx = {5'd3, 5'd3};
    @(negedge clk);
    #1;
    chk("clr_rd3", ra(0), 32'h0);
    wait_clear(n);
    we = '0;
    chk("clr_cycles", 32'(n + 1), 32'd31);
    chk("busy_s_low", 32'(busy_s), 32'd0);
    rd2(5'd3, 5'd3);
    chk("clr_wr_ignored", ra(0), 32'h0);

    wr(0, 5'd5, 32'hDEADBEEF);
    rd2(5'd5, 5'd0);
    chk("reg5_pre", ra(0), 32'hDEADBEEF);
    chk("reg0_p1", ra(1), 32'h0);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_clear(n);
    chk("rst2_cycles", 32'(n), 32'd31);
    rd2(5'd5, 5'd5);
    chk("reg5_cleared", ra(1), 32'h0);

    // Same-index collision: port1 must win.
    @(negedge clk);
    we = 2'b11;
    widx = {5'd7, 5'd7};
    wdat = {32'h22222222, 32'h11111111};
    @(negedge clk);
    we = '0;
    rd2(5'd7, 5'd7);
    chk("collide_p0", ra(0), 32'h22222222);
    chk("collide_p1", ra(1), 32'h22222222);

    @(negedge clk);
    we = 2'b01;
    widx = {5'd8, 5'd8};
    wdat = {32'hBBBBBBBB, 32'h00000088};
    @(negedge clk);
    we = '0;
    rd2(5'd8, 5'd7);
    chk("we_gate", ra(0), 32'h00000088);
    chk("other_reg", ra(1), 32'h22222222);

    // Zero register on every port.
    @(negedge clk);
    we = 2'b11;
    widx = '0;
    wdat = {32'hFFFFFFFF, 32'hFFFFFFFF};
    rd2(5'd0, 5'd0);
    chk("zero_fwd_p0", ra(0), 32'h0);
    chk("zero_fwd_p1", ra(1), 32'h0);
    @(negedge clk);
    we = '0;
    #1;
    chk("zero_s_p0", rs(0), 32'h0);
    chk("zero_a_p1", ra(1), 32'h0);

    // Forwarding on reg9.
    wr(0, 5'd9, 32'hA5A5A5A5);
    rd2(5'd9, 5'd9);
    chk("reg9_pre", ra(0), 32'hA5A5A5A5);
`ifdef RV32_REGFILE_BYPASS_EN
    exp_fwd = 32'h5A5A5A5A;
`else
    exp_fwd = 32'hA5A5A5A5;
`endif
    @(negedge clk);
    we = 2'b01;
    widx = {5'd0, 5'd9};
    wdat = {32'h0, 32'h5A5A5A5A};
    #1;
    chk("fwd_async", ra(1), exp_fwd);
    @(negedge clk);
    we = '0;
    #1;
    chk("fwd_sync", rs(0), exp_fwd);
    chk("fwd_after", ra(0), 32'h5A5A5A5A);

    // Registered read latency.
    wr(1, 5'd4, 32'hCAFE0004);
    rd2(5'd0, 5'd0);
    @(negedge clk);
    rd2(5'd4, 5'd0);
    chk("sync_lat_n", rs(0), 32'h0);
    @(negedge clk);
    #1;
    chk("sync_lat_n1", rs(0), 32'hCAFE0004);
    chk("async_reg4", ra(0), 32'hCAFE0004);

    // Reset during clear restarts the engine.
    wr(0, 5'd31, 32'h31313131);
    wr(1, 5'd10, 32'h10101010);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_busy", 32'(busy_a), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_clear(n);
    chk("mid_cycles", 32'(n), 32'd31);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rd2(5'(i), 5'(31 - i));
      chk($sformatf("all0_p0_r%0d", i), ra(0), 32'h0);
      chk($sformatf("all0_p1_r%0d", 31 - i),
          ra(1), 32'h0);
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
